// File: rtl/hv_bundle_seg_10_pkg.sv
// ---------------------------------------------------------------------------
// hv_bundle_seg_10_pkg
// Shared HDC definitions used by the segment bundler.
//   HV_DIM          : full hypervector width; one segment is HV_DIM/5 bits
//   FEATURES_PER_CC : level HVs presented per accepted beat
//   bundle_state_t  : bundler FSM states
// ---------------------------------------------------------------------------
package hv_bundle_seg_10_pkg;

    localparam int HV_DIM          = 1000;
    localparam int FEATURES_PER_CC = 59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_THRESH = 2'd2,
        ST_OUT    = 2'd3
    } bundle_state_t;

endpackage

// File: rtl/hv_bundle_seg_10_col_popcount.sv
// ---------------------------------------------------------------------------
// hv_col_popcount
// Counts the set bits of one column (same bit position across all level HVs
// of a beat).
//   col   : in  [N-1:0]  one bit from each level HV
//   count : out [W-1:0]  number of ones in col
// ---------------------------------------------------------------------------
module hv_col_popcount #(
    parameter int N = 59,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] col,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(col[i]);
        end
    end

endmodule

// File: rtl/hv_bundle_seg_10.sv
// ---------------------------------------------------------------------------
// hv_bundle_seg_10
// Bundles up to MAX_BEATS beats of level-HV segments into one thresholded
// segment: each bit keeps a running count of ones seen across the sample,
// and the output bit is set when that count exceeds the sampled threshold.
//   clk, rst           : clock, synchronous active-high reset
//   mapping_hv_segment : beat belongs to this segment
//   in_valid, in_last  : beat present / final beat of the sample
//   level_hvs          : FEATURES_PER_CC level HV segments, SEG_W bits each
//   cfg_threshold      : threshold, captured on the first beat of a sample
//   in_ready           : beat can be accepted (IDLE / ACCUM)
//   out_valid          : bundled_hv is presented (OUT)
//   out_ready          : consumer takes bundled_hv
//   bundled_hv         : thresholded bundle
//   err_overflow       : sticky, a sample ran to MAX_BEATS without in_last
// ---------------------------------------------------------------------------
module hv_bundle_seg_10
    import hv_bundle_seg_10_pkg::*;
#(
    parameter int SEG_W           = hv_bundle_seg_10_pkg::HV_DIM / 5,
    parameter int FEATURES_PER_CC = hv_bundle_seg_10_pkg::FEATURES_PER_CC,
    parameter int MAX_BEATS       = 10,
    parameter int CNT_W           = $clog2(FEATURES_PER_CC * MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mapping_hv_segment,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [SEG_W-1:0] level_hvs [0:FEATURES_PER_CC-1],
    input  logic [CNT_W-1:0] cfg_threshold,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEG_W-1:0] bundled_hv,
    output logic             err_overflow
);

    localparam int PC_W = $clog2(FEATURES_PER_CC + 1);
    localparam int BC_W = $clog2(MAX_BEATS + 1);

    bundle_state_t    state;
    logic [CNT_W-1:0] cnt [SEG_W];
    logic [PC_W-1:0]  pc  [SEG_W];
    logic [CNT_W-1:0] thr;
    logic [BC_W-1:0]  beats;
    logic [BC_W-1:0]  beats_nxt;
    logic             accept;
    logic             hit_max;
    logic             done;

    // Column popcounts: bit b of every level HV in the beat.
    for (genvar b = 0; b < SEG_W; b++) begin : g_col
        logic [FEATURES_PER_CC-1:0] col;

        always_comb begin
            col = '0;
            for (int f = 0; f < FEATURES_PER_CC; f++) begin
                col[f] = level_hvs[f][b];
            end
        end

        hv_col_popcount #(
            .N (FEATURES_PER_CC),
            .W (PC_W)
        ) u_pc (
            .col   (col),
            .count (pc[b])
        );
    end

    assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
    assign out_valid = (state == ST_OUT);
    assign accept    = in_valid && mapping_hv_segment && in_ready;

    // A beat taken in IDLE starts a fresh sample, so its index is 1.
    assign beats_nxt = (state == ST_IDLE) ? BC_W'(1) : beats + BC_W'(1);
    assign hit_max   = (beats_nxt == BC_W'(MAX_BEATS));
    assign done      = in_last || hit_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            thr          <= '0;
            beats        <= '0;
            bundled_hv   <= '0;
            err_overflow <= 1'b0;
            for (int b = 0; b < SEG_W; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        beats <= beats_nxt;
                        for (int b = 0; b < SEG_W; b++) begin
                            // IDLE discards whatever the previous sample left.
                            cnt[b] <= ((state == ST_IDLE) ? '0 : cnt[b]) + CNT_W'(pc[b]);
                        end
                        if (state == ST_IDLE) begin
                            thr <= cfg_threshold;
                        end
                        if (hit_max && !in_last) begin
                            err_overflow <= 1'b1;
                        end
                        state <= done ? ST_THRESH : ST_ACCUM;
                    end
                end
                ST_THRESH: begin
                    for (int b = 0; b < SEG_W; b++) begin
                        bundled_hv[b] <= (cnt[b] > thr);
                    end
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hv_bundle_seg_10.sv
// ---------------------------------------------------------------------------
// tb_hv_bundle_seg_10
// Scoreboard bench for hv_bundle_seg_10 with SEG_W=8, FEATURES_PER_CC=4,
// MAX_BEATS=3. Expected bundles are pushed when a sample's last beat is
// accepted and popped at each output handshake.
// ---------------------------------------------------------------------------
module tb_hv_bundle_seg_10;

    localparam int SEG_W = 8;
    localparam int FPC   = 4;
    localparam int MB    = 3;
    localparam int CW    = $clog2(FPC * MB + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mapping_hv_segment = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic [SEG_W-1:0] lv [0:FPC-1];
    logic [CW-1:0]    cfg_threshold = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [SEG_W-1:0] bundled_hv;
    logic             err_overflow;

    hv_bundle_seg_10 #(
        .SEG_W           (SEG_W),
        .FEATURES_PER_CC (FPC),
        .MAX_BEATS       (MB),
        .CNT_W           (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mapping_hv_segment (mapping_hv_segment),
        .in_valid           (in_valid),
        .in_last            (in_last),
        .level_hvs          (lv),
        .cfg_threshold      (cfg_threshold),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .bundled_hv         (bundled_hv),
        .err_overflow       (err_overflow)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [7:0]   exp_q [$];
    int           mc [SEG_W];
    int           mbeats = 0;
    int           mthr = 0;
    logic         exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_out", exp_q.size(), 1);
            else                   chk("bundle", bundled_hv, exp_q.pop_front());
        end
    end

    // Reference model of one accepted beat.
    task automatic model_beat(input logic [31:0] hvs, input bit last, input int thr);
        logic [7:0] e;
        if (mbeats == 0) begin
            for (int b = 0; b < SEG_W; b++) mc[b] = 0;
            mthr = thr;
        end
        for (int f = 0; f < FPC; f++)
            for (int b = 0; b < SEG_W; b++)
                mc[b] += int'(hvs[8*f+b]);
        mbeats++;
        if (last || mbeats == MB) begin
            if (!last) exp_err = 1'b1;
            e = '0;
            for (int b = 0; b < SEG_W; b++) e[b] = (mc[b] > mthr);
            exp_q.push_back(e);
            mbeats = 0;
        end
    endtask

    // Drive one beat; a mapped beat waits (bounded) for acceptance.
    task automatic beat(input logic [31:0] hvs, input bit last, input int thr, input bit map);
        int k;
        @(negedge clk);
        for (int f = 0; f < FPC; f++) lv[f] = hvs[8*f +: 8];
        in_last            = last;
        cfg_threshold      = CW'(thr);
        mapping_hv_segment = map;
        in_valid           = 1'b1;
        if (!map) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            chk("accept_timeout", k, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            model_beat(hvs, last, thr);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bundled", bundled_hv, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        rst     = 1'b0;
        mbeats  = 0;
        exp_err = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] held;
        for (int f = 0; f < FPC; f++) lv[f] = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Single full beat, threshold 3, latency t+2.
        beat(32'hFFFF_FFFF, 1'b1, 3, 1'b1);
        @(negedge clk);
        chk("lat_t1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_t2_out_valid", out_valid, 1);
        chk("lat_t2_bundled", bundled_hv, 8'hFF);
        drain();

        // Two beats {0F,0F,F0,00}: counts 4 (b0..3) and 2 (b4..7), threshold 3.
        beat(32'h00F0_0F0F, 1'b0, 3, 1'b1);
        beat(32'h00F0_0F0F, 1'b1, 9, 1'b1);
        drain();

        // Same run with an ignored beat in the middle.
        beat(32'h00F0_0F0F, 1'b0, 3, 1'b1);
        beat(32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        beat(32'h00F0_0F0F, 1'b1, 9, 1'b1);
        drain();

        // Overflow: three non-last beats, consumer stalls.
        out_ready = 1'b0;
        beat(32'h0103_070F, 1'b0, 2, 1'b1);
        beat(32'h0103_070F, 1'b0, 7, 1'b1);
        beat(32'h0103_070F, 1'b0, 7, 1'b1);
        @(negedge clk);
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_err", err_overflow, 1);
        chk("ovf_thresh_out_valid", out_valid, 0);
        in_valid = 1'b1;
        mapping_hv_segment = 1'b1;
        in_last = 1'b0;
        @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_expected", bundled_hv, exp_q.size() > 0 ? exp_q[0] : 8'h00);
        held = bundled_hv;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", bundled_hv, held);
            chk("stall_no_accept", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        chk("err_sticky", err_overflow, exp_err);
        drain();

        // Reset mid-sample abandons it.
        beat(32'hFFFF_FFFF, 1'b0, 5, 1'b1);
        do_reset();
        beat(32'h0000_0000, 1'b1, 0, 1'b1);
        drain();
        chk("err_after_reset", err_overflow, exp_err);

        // Random samples with ignored beats sprinkled in.
        for (int s = 0; s < 8; s++) begin
            int nb;
            int th;
            nb = $urandom_range(1, MB);
            th = $urandom_range(0, FPC * MB);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 2) == 0) beat($urandom(), $urandom_range(0, 1), th, 1'b0);
                beat($urandom(), (i == nb - 1), th, 1'b1);
            end
            drain();
        end
        chk("final_err", err_overflow, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
